// File: rtl/csr_hpm_counters.sv
// Hardware performance-monitor counters mhpmcounter3.. with per-counter event
// selectors, inhibit/enable masks and a registered overflow interrupt.
module csr_hpm_counters #(
  parameter int NUM_COUNTERS = 4,
  parameter int CNT_WIDTH    = 64,
  parameter int NUM_EVENTS   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [11:0]           csrAddr_i,
  input  logic [31:0]           csrWData_i,
  input  logic [1:0]            csrOp_i,
  input  logic [1:0]            privilege_i,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic [31:0]           csrRData_o,
  output logic                  csrHit_o,
  output logic                  csrIllegal_o,
  output logic                  ovfIrq_o
);
  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0]    cnt_q  [NUM_COUNTERS];
  logic [NUM_EVENTS-1:0]   mask_q [NUM_COUNTERS];
  logic                    of_q   [NUM_COUNTERS];
  logic                    ofie_q [NUM_COUNTERS];
  logic                    en_q   [NUM_COUNTERS];
  logic                    inh_q  [NUM_COUNTERS];
  logic                    irq_reg, irq_next;

  logic [4:0]              n_sel, idx;
  logic [6:0]              blk;
  logic                    n_ok, impl;
  logic                    sel_en, sel_inh, sel_evt, sel_cnt, sel_cnth, sel_ucnt, sel_ucnth;
  logic                    m_rng, u_rng, we;
  logic [CNT_WIDTH-1:0]    cnt_sel;
  logic [31:0]             evt_sel, en_full, inh_full, old_val, new_val;
  logic                    en_bit;
  logic [NUM_COUNTERS-1:0] en_vec, inh_vec;

  // Counter-indexed ranges are 32-entry blocks; only N >= 3 exists in each.
  assign n_sel     = csrAddr_i[4:0];
  assign blk       = csrAddr_i[11:5];
  assign n_ok      = (n_sel >= 5'd3);
  assign idx       = n_sel - 5'd3;
  assign impl      = n_ok && (idx < 5'(NUM_COUNTERS));

  assign sel_en    = (csrAddr_i == 12'h306);
  assign sel_inh   = (csrAddr_i == 12'h320);
  assign sel_evt   = (blk == 7'h19) && n_ok;
  assign sel_cnt   = (blk == 7'h58) && n_ok;
  assign sel_cnth  = (blk == 7'h5C) && n_ok;
  assign sel_ucnt  = (blk == 7'h60) && n_ok;
  assign sel_ucnth = (blk == 7'h64) && n_ok;

  assign m_rng     = sel_en || sel_inh || sel_evt || sel_cnt || sel_cnth;
  assign u_rng     = sel_ucnt || sel_ucnth;

  always_comb begin
    cnt_sel  = '0;
    evt_sel  = '0;
    en_bit   = 1'b0;
    en_vec   = '0;
    inh_vec  = '0;
    irq_next = 1'b0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      en_vec[i]  = en_q[i];
      inh_vec[i] = inh_q[i];
      irq_next   = irq_next | (of_q[i] & ofie_q[i]);
      if (impl && (idx == 5'(i))) begin
        cnt_sel = cnt_q[i];
        evt_sel = {of_q[i], ofie_q[i], 30'(mask_q[i])};
        en_bit  = en_q[i];
      end
    end
  end

  assign en_full  = 32'(en_vec) << 3;
  assign inh_full = 32'(inh_vec) << 3;

  always_comb begin
    old_val = '0;
    if (sel_en)                      old_val = en_full;
    else if (sel_inh)                old_val = inh_full;
    else if (sel_evt)                old_val = evt_sel;
    else if (sel_cnt || sel_ucnt)    old_val = cnt_sel[31:0];
    else if (sel_cnth || sel_ucnth)  old_val = 32'(cnt_sel[CNT_WIDTH-1:32]);
  end

  always_comb begin
    case (csrOp_i)
      2'b10:   new_val = old_val | csrWData_i;
      2'b11:   new_val = old_val & ~csrWData_i;
      default: new_val = csrWData_i;
    endcase
  end

  assign csrRData_o   = old_val;
  assign csrHit_o     = m_rng || u_rng;
  assign csrIllegal_o = (u_rng && (csrOp_i != 2'b00)) ||
                        (m_rng && (privilege_i != 2'd3)) ||
                        (u_rng && (privilege_i != 2'd3) && !en_bit);
  assign we           = (csrOp_i != 2'b00) && csrHit_o && !csrIllegal_o;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
      logic                  hit_i, wr_lo, wr_hi, wr_evt, inc, wrap;
      logic [CNT_WIDTH-1:0]  cnt_reg;
      logic [NUM_EVENTS-1:0] mask_reg;
      logic                  of_reg, ofie_reg, en_reg, inh_reg;

      assign hit_i  = impl && (idx == 5'(gi));
      assign wr_lo  = we && sel_cnt && hit_i;
      assign wr_hi  = we && sel_cnth && hit_i;
      assign wr_evt = we && sel_evt && hit_i;
      assign inc    = !inh_reg && (|(events_i & mask_reg));
      // A software write to the counter swallows this cycle's increment, so no overflow.
      assign wrap   = inc && (&cnt_reg) && !wr_lo && !wr_hi;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          cnt_reg  <= '0;
          mask_reg <= '0;
          of_reg   <= 1'b0;
          ofie_reg <= 1'b0;
          en_reg   <= 1'b0;
          inh_reg  <= 1'b0;
        end else begin
          if (wr_lo)      cnt_reg[31:0]           <= new_val;
          else if (wr_hi) cnt_reg[CNT_WIDTH-1:32] <= new_val[HI_W-1:0];
          else if (inc)   cnt_reg                 <= cnt_reg + CNT_WIDTH'(1);
          if (wr_evt) begin
            mask_reg <= new_val[NUM_EVENTS-1:0];
            ofie_reg <= new_val[30];
          end
          if (wrap)        of_reg <= 1'b1;
          else if (wr_evt) of_reg <= new_val[31];
          if (we && sel_en)  en_reg  <= new_val[gi+3];
          if (we && sel_inh) inh_reg <= new_val[gi+3];
        end
      end

      assign cnt_q[gi]  = cnt_reg;
      assign mask_q[gi] = mask_reg;
      assign of_q[gi]   = of_reg;
      assign ofie_q[gi] = ofie_reg;
      assign en_q[gi]   = en_reg;
      assign inh_q[gi]  = inh_reg;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) irq_reg <= 1'b0;
    else           irq_reg <= irq_next;
  end

  assign ovfIrq_o = irq_reg;
endmodule

// File: tb/tb_csr_hpm_counters.sv
// Scoreboard bench for csr_hpm_counters: driver pushes model expectations,
// a negedge monitor pops and compares read data, hit, illegal and interrupt.
module tb_csr_hpm_counters;
  localparam int NC = 4;
  localparam int CW = 40;
  localparam int NE = 8;
  localparam logic [63:0] CW_MASK  = (64'd1 << CW) - 64'd1;
  localparam logic [31:0] EN_MASK  = ((32'd1 << NC) - 32'd1) << 3;
  localparam logic [31:0] EVT_MASK = ((32'd1 << NE) - 32'd1) | 32'hC000_0000;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic [11:0]   csrAddr_i = '0;
  logic [31:0]   csrWData_i = '0;
  logic [1:0]    csrOp_i = '0;
  logic [1:0]    privilege_i = 2'd3;
  logic [NE-1:0] events_i = '0;
  logic [31:0]   csrRData_o;
  logic          csrHit_o, csrIllegal_o, ovfIrq_o;

  csr_hpm_counters #(.NUM_COUNTERS(NC), .CNT_WIDTH(CW), .NUM_EVENTS(NE)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .csrAddr_i(csrAddr_i), .csrWData_i(csrWData_i),
    .csrOp_i(csrOp_i), .privilege_i(privilege_i), .events_i(events_i),
    .csrRData_o(csrRData_o), .csrHit_o(csrHit_o), .csrIllegal_o(csrIllegal_o),
    .ovfIrq_o(ovfIrq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] rd;
    logic        hit, ill, irq;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: CSR images per counter index 0..31, counters as 64-bit values.
  logic [63:0] m_cnt [32];
  logic [31:0] m_evt [32];
  logic [31:0] m_en, m_inh;
  logic        m_irq;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = '0;
      m_evt[i] = '0;
    end
    m_en  = '0;
    m_inh = '0;
    m_irq = 1'b0;
  endfunction

  function automatic bit impl(input int n);
    return (n >= 3) && (n <= NC + 2);
  endfunction

  // kind: 0 none, 1 mcounteren, 2 mcountinhibit, 3 mhpmevent, 4/5 mhpmcounter lo/hi, 6/7 hpmcounter lo/hi
  function automatic void decode(input logic [11:0] a, output int kind, output int n);
    int v;
    v = a;
    kind = 0;
    n = 0;
    if (v == 'h306) kind = 1;
    else if (v == 'h320) kind = 2;
    else if (v >= 'h323 && v <= 'h33F) begin kind = 3; n = v - 'h320; end
    else if (v >= 'hB03 && v <= 'hB1F) begin kind = 4; n = v - 'hB00; end
    else if (v >= 'hB83 && v <= 'hB9F) begin kind = 5; n = v - 'hB80; end
    else if (v >= 'hC03 && v <= 'hC1F) begin kind = 6; n = v - 'hC00; end
    else if (v >= 'hC83 && v <= 'hC9F) begin kind = 7; n = v - 'hC80; end
  endfunction

  function automatic void model_read(input logic [11:0] a, input logic [1:0] pr, input logic [1:0] op,
                                     output logic [31:0] rd, output logic hit, output logic ill);
    int  kind, n;
    bit  mr, ur;
    decode(a, kind, n);
    hit = (kind != 0);
    mr  = (kind >= 1) && (kind <= 5);
    ur  = (kind >= 6);
    ill = (ur && op != 2'b00) || (mr && pr != 2'd3) || (ur && pr != 2'd3 && !m_en[n]);
    case (kind)
      1:       rd = m_en;
      2:       rd = m_inh;
      3:       rd = m_evt[n];
      4, 6:    rd = m_cnt[n][31:0];
      5, 7:    rd = m_cnt[n][63:32];
      default: rd = '0;
    endcase
  endfunction

  function automatic void model_step(input logic [11:0] a, input logic [31:0] wd, input logic [1:0] op,
                                     input logic [1:0] pr, input logic [NE-1:0] ev, input bit rst);
    int          kind, n, cnt_wr;
    bit          inc [32];
    logic        irq_n, hit, ill;
    logic [31:0] old, nw;
    if (rst) begin
      model_clear();
      return;
    end
    decode(a, kind, n);
    irq_n = 1'b0;
    for (int k = 0; k < 32; k++) begin
      inc[k] = impl(k) && !m_inh[k] && ((ev & m_evt[k][NE-1:0]) != '0);
      if (impl(k)) irq_n = irq_n | (m_evt[k][31] & m_evt[k][30]);
    end
    model_read(a, pr, op, old, hit, ill);
    cnt_wr = -1;
    if (hit && !ill && op != 2'b00) begin
      nw = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
      case (kind)
        1: m_en  = nw & EN_MASK;
        2: m_inh = nw & EN_MASK;
        3: if (impl(n)) m_evt[n] = nw & EVT_MASK;
        4: if (impl(n)) begin m_cnt[n] = {m_cnt[n][63:32], nw} & CW_MASK; cnt_wr = n; end
        5: if (impl(n)) begin m_cnt[n] = {nw, m_cnt[n][31:0]} & CW_MASK; cnt_wr = n; end
        default: ;
      endcase
    end
    for (int k = 0; k < 32; k++) begin
      if (inc[k] && k != cnt_wr) begin
        if (m_cnt[k] == CW_MASK) begin
          m_cnt[k] = '0;
          m_evt[k][31] = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + 64'd1;
        end
      end
    end
    m_irq = irq_n;
  endfunction

  // One transaction per cycle; c_irq < 0 takes the interrupt expectation from the model.
  task automatic cyc(input logic [11:0] a, input logic [31:0] wd, input logic [1:0] op,
                     input logic [1:0] pr, input logic [NE-1:0] ev, input bit rst,
                     input bit use_c, input logic [31:0] c_rd, input bit c_ill, input int c_irq);
    exp_t        e;
    logic [31:0] rd;
    logic        hit, ill;
    csrAddr_i   = a;
    csrWData_i  = wd;
    csrOp_i     = op;
    privilege_i = pr;
    events_i    = ev;
    reset_ni    = !rst;
    if (rst) model_clear();
    model_read(a, pr, op, rd, hit, ill);
    e.addr = a;
    e.hit  = hit;
    e.rd   = use_c ? c_rd : rd;
    e.ill  = use_c ? c_ill : ill;
    e.irq  = (c_irq < 0) ? m_irq : (c_irq != 0);
    sb.push_back(e);
    @(posedge clk_i);
    model_step(a, wd, op, pr, ev, rst);
    #1;
  endtask

  task automatic chk(input logic [11:0] a, input logic [1:0] pr, input logic [NE-1:0] ev,
                     input logic [31:0] rd, input bit ill, input int irq);
    cyc(a, 32'h0, 2'b00, pr, ev, 1'b0, 1'b1, rd, ill, irq);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd, input logic [1:0] op);
    cyc(a, wd, op, 2'd3, '0, 1'b0, 1'b0, 32'h0, 1'b0, -1);
  endtask

  task automatic idle(input logic [NE-1:0] ev, input int cycles);
    repeat (cycles) cyc(12'h000, 32'h0, 2'b00, 2'd3, ev, 1'b0, 1'b0, 32'h0, 1'b0, -1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (csrRData_o !== e.rd) begin
          miscompares++;
          $display("FAIL rdata addr=%h got %h expected %h", e.addr, csrRData_o, e.rd);
        end
        if (csrHit_o !== e.hit) begin
          miscompares++;
          $display("FAIL hit addr=%h got %b expected %b", e.addr, csrHit_o, e.hit);
        end
        if (csrIllegal_o !== e.ill) begin
          miscompares++;
          $display("FAIL illegal addr=%h got %b expected %b", e.addr, csrIllegal_o, e.ill);
        end
        if (ovfIrq_o !== e.irq) begin
          miscompares++;
          $display("FAIL irq addr=%h got %b expected %b", e.addr, ovfIrq_o, e.irq);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout, vectors=%0d", vectors);
    $fatal(1, "simulation did not complete");
  end

  initial begin : driver
    logic [11:0] a;
    logic [31:0] wd;
    int          k, n, r;
    model_clear();
    @(posedge clk_i);
    #1;

    // Reset state and writes ignored while reset is held.
    cyc(12'hB03, 32'h0, 2'b00, 2'd3, '1, 1'b1, 1'b1, 32'h0, 1'b0, 0);
    cyc(12'h306, 32'hFFFF_FFFF, 2'b01, 2'd3, '0, 1'b1, 1'b1, 32'h0, 1'b0, 0);
    // Write coincident with the first edge after release takes effect.
    cyc(12'h323, 32'h1, 2'b01, 2'd3, '0, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    chk(12'h323, 2'd3, '0, 32'h1, 1'b0, 0);
    chk(12'h306, 2'd3, '0, 32'h0, 1'b0, 0);

    // Ten events count to ten; inhibited counter holds.
    idle(8'h01, 10);
    chk(12'hC03, 2'd3, '0, 32'd10, 1'b0, 0);
    wr(12'h320, 32'h8, 2'b01);
    idle(8'h01, 10);
    chk(12'hC03, 2'd3, '0, 32'd10, 1'b0, 0);
    wr(12'h320, 32'hFFFF_FFFF, 2'b10);
    chk(12'h320, 2'd3, '0, 32'h78, 1'b0, 0);
    wr(12'h320, 32'hFFFF_FFFF, 2'b11);
    chk(12'h320, 2'd3, '0, 32'h0, 1'b0, 0);

    // User-mode access gated by mcounteren.
    chk(12'hC03, 2'd0, '0, 32'd10, 1'b1, 0);
    wr(12'h306, 32'h8, 2'b10);
    chk(12'h306, 2'd3, '0, 32'h8, 1'b0, 0);
    chk(12'hC03, 2'd0, '0, 32'd10, 1'b0, 0);
    chk(12'hC83, 2'd0, '0, 32'h0, 1'b0, 0);
    chk(12'hC04, 2'd0, '0, 32'h0, 1'b1, 0);
    chk(12'hB03, 2'd1, '0, 32'd10, 1'b1, 0);

    // Illegal writes leave the counter untouched.
    cyc(12'hC03, 32'h55, 2'b01, 2'd3, '0, 1'b0, 1'b1, 32'd10, 1'b1, 0);
    cyc(12'hB03, 32'h55, 2'b01, 2'd0, '0, 1'b0, 1'b1, 32'd10, 1'b1, 0);
    chk(12'hB03, 2'd3, '0, 32'd10, 1'b0, 0);

    // Overflow from all-ones sets OF; interrupt follows one cycle later.
    wr(12'hB03, 32'hFFFF_FFFF, 2'b01);
    wr(12'hB83, 32'hFFFF_FFFF, 2'b01);
    wr(12'h323, 32'h4000_0001, 2'b01);
    chk(12'hB83, 2'd3, '0, 32'h0000_00FF, 1'b0, 0);
    chk(12'hC03, 2'd3, '0, 32'hFFFF_FFFF, 1'b0, 0);
    idle(8'h01, 1);
    chk(12'h323, 2'd3, '0, 32'hC000_0001, 1'b0, 0);
    chk(12'hB03, 2'd3, '0, 32'h0, 1'b0, 1);
    chk(12'hB83, 2'd3, '0, 32'h0, 1'b0, 1);

    // Software clear of OF loses against a simultaneous hardware overflow.
    wr(12'h323, 32'h8000_0000, 2'b11);
    wr(12'hB03, 32'hFFFF_FFFF, 2'b01);
    wr(12'hB83, 32'h0000_00FF, 2'b01);
    cyc(12'h323, 32'h8000_0000, 2'b11, 2'd3, 8'h01, 1'b0, 1'b1, 32'h4000_0001, 1'b0, 0);
    chk(12'h323, 2'd3, '0, 32'hC000_0001, 1'b0, 0);
    chk(12'hB03, 2'd3, '0, 32'h0, 1'b0, 1);

    // Write wins over a coincident increment.
    wr(12'h324, 32'h1, 2'b01);
    cyc(12'hB04, 32'h100, 2'b01, 2'd3, 8'h01, 1'b0, 1'b0, 32'h0, 1'b0, -1);
    chk(12'hB04, 2'd3, '0, 32'h100, 1'b0, 1);

    // Unimplemented counter indices: hit, read zero, writes dropped.
    chk(12'hB07, 2'd3, '0, 32'h0, 1'b0, 1);
    wr(12'hB07, 32'h1234, 2'b01);
    chk(12'hB07, 2'd3, '0, 32'h0, 1'b0, 1);
    chk(12'h33F, 2'd3, '0, 32'h0, 1'b0, 1);
    chk(12'hC07, 2'd0, '0, 32'h0, 1'b1, 1);
    chk(12'hB00, 2'd3, '0, 32'h0, 1'b0, 1);

    // Reset mid-count clears everything immediately.
    wr(12'hB03, 32'h1230, 2'b01);
    idle(8'h01, 4);
    chk(12'hC03, 2'd3, 8'h01, 32'h1234, 1'b0, 1);
    cyc(12'hB03, 32'h0, 2'b00, 2'd3, 8'h01, 1'b1, 1'b1, 32'h0, 1'b0, 0);
    cyc(12'h323, 32'h0, 2'b00, 2'd3, 8'h01, 1'b1, 1'b1, 32'h0, 1'b0, 0);
    chk(12'hB03, 2'd3, 8'h01, 32'h0, 1'b0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NC + 4);
      case (k)
        0:       a = 12'h306;
        1:       a = 12'h320;
        2:       a = 12'(32'h320 + n);
        3, 8:    a = 12'(32'hB00 + n);
        4, 9:    a = 12'(32'hB80 + n);
        5:       a = 12'(32'hC00 + n);
        6:       a = 12'(32'hC80 + n);
        default: a = 12'($urandom_range(0, 4095));
      endcase
      r = $urandom_range(0, 3);
      case (r)
        0:       wd = $urandom;
        1:       wd = 32'hFFFF_FFFF;
        2:       wd = 32'hFFFF_FFF0;
        default: wd = 32'h1 << $urandom_range(0, 31);
      endcase
      r = $urandom_range(0, 4);
      cyc(a, wd, 2'($urandom_range(0, 3)), (r < 3) ? 2'd3 : 2'($urandom_range(0, 2)),
          NE'($urandom & $urandom), ($urandom_range(0, 299) == 0), 1'b0, 32'h0, 1'b0, -1);
    end

    @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/csr_hpm_counters.md
CSR_HPM_COUNTERS -- requirements
Module: csr_hpm_counters

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 4, number of HPM counters (legal 1..29), indices N = 3..NUM_COUNTERS+2.
REQ-002 SHALL have parameter CNT_WIDTH, default 64, implemented counter width (legal 33..64).
REQ-003 SHALL have parameter NUM_EVENTS, default 8, number of event inputs (legal 1..30).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port csrAddr_i  input  12  CSR address for read and write.
REQ-007 SHALL have port csrWData_i  input  32  write operand.
REQ-008 SHALL have port csrOp_i  input  2  00 none, 01 write, 10 set bits, 11 clear bits.
REQ-009 SHALL have port privilege_i  input  2  current privilege (0 U, 1 S, 3 M).
REQ-010 SHALL have port events_i  input  NUM_EVENTS  per-cycle event pulses.
REQ-011 SHALL have port csrRData_o  output  32  combinational read data.
REQ-012 SHALL have port csrHit_o  output  1  csrAddr_i decodes to a CSR in this block.
REQ-013 SHALL have port csrIllegal_o  output  1  access must raise illegal-instruction.
REQ-014 SHALL have port ovfIrq_o  output  1  registered overflow interrupt request.

Function
REQ-015 SHALL decode: mcounteren 0x306, mcountinhibit 0x320, mhpmeventN 0x320+N, mhpmcounterN 0xB00+N, mhpmcounterNh 0xB80+N, hpmcounterN 0xC00+N, hpmcounterNh 0xC80+N; other addresses give csrHit_o=0 and csrRData_o=0.
REQ-016 SHALL return csrRData_o as the pre-write value of the addressed CSR in the same cycle; counter bits at or above CNT_WIDTH read 0.
REQ-017 SHALL compute new value = wdata (01), old|wdata (10), old&~wdata (11); op 00 SHALL change nothing.
REQ-018 SHALL implement mcounteren and mcountinhibit bits [N] only; other bits read 0 and ignore writes.
REQ-019 SHALL implement mhpmeventN bits [NUM_EVENTS-1:0] as event mask, bit 30 OFIE, bit 31 OF; other bits read 0.
REQ-020 SHALL increment counter N by exactly 1 per cycle when mcountinhibit[N]=0 and (events_i & mask_N) != 0; result visible on the following cycle.
REQ-021 SHALL wrap counter N from all-ones (CNT_WIDTH bits) to 0 and set OF_N in the same edge.
REQ-022 SHALL, on a write to mhpmcounterN (or ...h), load that half with the new value, hold the other half at its pre-edge value, and drop that cycle's increment.
REQ-023 SHALL, when software clears OF_N in the same cycle as a hardware overflow of counter N, leave OF_N=1 (hardware set wins).
REQ-024 SHALL drive ovfIrq_o, registered, = OR over N of (OF_N & OFIE_N); one-cycle latency from OF/OFIE change.
REQ-025 SHALL assert csrIllegal_o, with no state change, for: any op!=00 to 0xC00/0xC80 range; any access to 0x306/0x320-0x33F/0xB00-0xB9F with privilege_i!=3; hpmcounter read with privilege_i!=3 and mcounteren[N]=0.
REQ-026 SHALL treat addresses for N beyond NUM_COUNTERS+2 within decoded ranges as hit, read 0, writes ignored, never illegal in M mode.
REQ-027 SHALL keep csrIllegal_o and csrHit_o purely combinational and 0 when csrAddr_i is not decoded.

Reset
REQ-028 SHALL, while reset_ni=0, asynchronously clear all counters, masks, OF, OFIE, mcounteren, mcountinhibit and ovfIrq_o to 0.
REQ-029 SHALL resume counting on the first rising edge after reset_ni deasserts; a write coincident with that edge SHALL take effect.
REQ-030 SHALL abandon any in-flight increment or write when reset asserts mid-cycle; no partial update.

Verification
REQ-031 SHALL cover: mask3=0x01, events_i=0x01 for 10 cycles -> hpmcounter3 reads 10; inhibit[3]=1 then 10 more cycles -> still 10.
REQ-032 SHALL cover: write mhpmcounter3=0xFFFFFFFF, mhpmcounter3h=0xFFFFFFFF, OFIE3=1, one event -> counter 0, OF3=1, ovfIrq_o=1 next cycle.
REQ-033 SHALL cover: event active and write mhpmcounter4=0x100 same cycle -> reads 0x100 next cycle, not 0x101.
REQ-034 SHALL cover: privilege_i=0, mcounteren=0, read 0xC03 -> csrIllegal_o=1; set mcounteren[3]=1 -> csrIllegal_o=0, correct data.
REQ-035 SHALL cover: op 01 to 0xC03 in M mode -> csrIllegal_o=1, counter unchanged; op 11 on mhpmevent3 with 0x80000000 during overflow -> OF3 stays 1.
REQ-036 SHALL cover: reset_ni low mid-count with counter 0x1234 -> all reads 0 immediately, ovfIrq_o=0.
